// File: rtl/seq_mult_fsm_pkg.sv
// Shared definitions for the sequential shift-add multiplier: default operand width and
// the control FSM state encoding.
package seq_mult_fsm_pkg;

  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } mult_state_t;

endpackage

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: operand registers, right-shifting accumulator and the product
// register, sequenced by load/step/latch strobes from the control FSM.
module seq_mult_datapath #(
  parameter int unsigned Width = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               latch_i,
  input  logic [Width-1:0]   mcand_i,
  input  logic [Width-1:0]   mplier_i,
  output logic [2*Width-1:0] product_o
);

  logic [Width-1:0]   mcand_q, mcand_d;
  logic [Width-1:0]   mplier_q, mplier_d;
  logic [2*Width-1:0] acc_q, acc_d;
  logic [2*Width-1:0] product_q, product_d;
  logic [2*Width-1:0] acc_step;
  logic [Width-1:0]   addend;
  logic [Width:0]     upper_sum;

  // The low half of acc starts at zero, so the bit shifted out each step carries nothing.
  logic unused_acc_lsb;
  assign unused_acc_lsb = acc_q[0];

  always_comb begin
    addend    = mplier_q[0] ? mcand_q : '0;
    upper_sum = {1'b0, acc_q[2*Width-1:Width]} + {1'b0, addend};
    acc_step  = {upper_sum, acc_q[Width-1:1]};

    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;

    if (load_i) begin
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      acc_d    = '0;
    end else if (step_i) begin
      acc_d    = acc_step;
      mplier_d = mplier_q >> 1;
    end

    // The final step's sum goes straight to the product so DONE shows it immediately.
    if (latch_i) begin
      product_d = acc_step;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign product_o = product_q;

endmodule

// File: rtl/seq_mult_fsm.sv
// Control FSM for the unsigned sequential multiplier; drives the sibling iteration counter
// and the shift-add datapath, with start/ready and valid/ready handshakes.
module seq_mult_fsm
  import seq_mult_fsm_pkg::*;
#(
  parameter int unsigned Width = DW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               start_i,
  output logic               ready_o,
  input  logic [Width-1:0]   multiplicand_i,
  input  logic [Width-1:0]   multiplier_i,
  output logic [2*Width-1:0] product_o,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic               cnt_enable_o,
  output logic               cnt_sync_reset_o,
  input  logic               cnt_flag_i
);

  mult_state_t state_q, state_d;
  logic        load, step, latch;

  always_comb begin
    state_d          = state_q;
    load             = 1'b0;
    step             = 1'b0;
    latch            = 1'b0;
    ready_o          = 1'b0;
    result_valid_o   = 1'b0;
    cnt_enable_o     = 1'b0;
    cnt_sync_reset_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready_o = 1'b1;
        if (start_i) begin
          load    = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_enable_o     = 1'b1;
        cnt_sync_reset_o = 1'b1;
        state_d          = StRun;
      end
      StRun: begin
        step = 1'b1;
        // Hold the counter at its terminal value on the last step.
        cnt_enable_o = ~cnt_flag_i;
        if (cnt_flag_i) begin
          latch   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        result_valid_o = 1'b1;
        if (result_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over every transition and must not disturb operands or product.
    if (clear_i) begin
      state_d = StIdle;
      load    = 1'b0;
      step    = 1'b0;
      latch   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  seq_mult_datapath #(
    .Width(Width)
  ) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load),
    .step_i   (step),
    .latch_i  (latch),
    .mcand_i  (multiplicand_i),
    .mplier_i (multiplier_i),
    .product_o(product_o)
  );

endmodule

// File: tb/tb_seq_mult_fsm.sv
// Bench for seq_mult_fsm with a behavioural iteration counter alongside; expected products
// are queued at operand acceptance and compared when the result is presented.
module tb_seq_mult_fsm;

  localparam int unsigned W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           clear;
  logic           start;
  logic           ready;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [2*W-1:0] product;
  logic           result_valid;
  logic           result_ready;
  logic           cnt_enable;
  logic           cnt_sync_reset;
  logic           cnt_flag;

  logic [4:0]     cnt_q;
  logic [31:0]    sb_q[$];
  logic [31:0]    last_prod;
  int             n_checks = 0;
  int             n_pass = 0;

  always #5 clk = ~clk;

  seq_mult_fsm #(
    .Width(W)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .clear_i         (clear),
    .start_i         (start),
    .ready_o         (ready),
    .multiplicand_i  (multiplicand),
    .multiplier_i    (multiplier),
    .product_o       (product),
    .result_valid_o  (result_valid),
    .result_ready_i  (result_ready),
    .cnt_enable_o    (cnt_enable),
    .cnt_sync_reset_o(cnt_sync_reset),
    .cnt_flag_i      (cnt_flag)
  );

  // Sibling counter: clears only when enable and sync_reset are both high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (cnt_enable) begin
      cnt_q <= cnt_sync_reset ? 5'd0 : cnt_q + 5'd1;
    end
  end
  assign cnt_flag = (cnt_q == 5'(W - 1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT in IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        input bit tie);
    int          cyc, en_cnt, sr_cnt, sr_at;
    logic [31:0] exp_p, held;
    check("ready_idle", ready, 1);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    result_ready = tie;
    sb_q.push_back(32'(a) * 32'(b));
    @(posedge clk);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    cyc    = 1;
    en_cnt = 0;
    sr_cnt = 0;
    sr_at  = -1;
    while (!result_valid && cyc < 100) begin
      if (cnt_enable) en_cnt++;
      if (cnt_sync_reset) begin
        sr_cnt++;
        sr_at = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    if (!result_valid) begin
      check("valid_timeout", result_valid, 1);
      void'(sb_q.pop_front());
      return;
    end
    check("latency", cyc, W + 2);
    check("cnt_en_cycles", en_cnt, W);
    check("cnt_sr_cycles", sr_cnt, 1);
    check("cnt_sr_in_load", sr_at, 1);
    check("cnt_en_done", cnt_enable, 0);
    exp_p = sb_q.pop_front();
    check("product", product, exp_p);
    last_prod = exp_p;
    held = product;
    if (!tie) begin
      for (int i = 0; i < hold; i++) begin
        start = (i == 2);
        if (i == 2) begin
          multiplicand = 16'h1234;
          multiplier   = 16'h4321;
        end
        @(negedge clk);
        check("valid_hold", result_valid, 1);
        check("product_hold", product, held);
        check("ready_busy", ready, 0);
      end
      start        = 1'b0;
      result_ready = 1'b1;
    end
    @(negedge clk);
    if (!tie) result_ready = 1'b0;
    check("ready_after", ready, 1);
    check("valid_drop", result_valid, 0);
    check("product_keep", product, held);
  endtask

  initial begin
    int nvalid;
    reset        = 1'b0;
    clear        = 1'b0;
    start        = 1'b0;
    result_ready = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    last_prod    = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_valid", result_valid, 0);
    check("rst_product", product, 0);
    check("rst_cnt_en", cnt_enable, 0);
    check("rst_cnt_sr", cnt_sync_reset, 0);
    reset = 1'b1;
    @(negedge clk);

    run_op(16'd3, 16'd5, 0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 0, 1'b0);
    run_op(16'h0000, 16'hABCD, 0, 1'b0);
    run_op(16'h0001, 16'h8000, 0, 1'b0);
    run_op(16'd1234, 16'd5678, 10, 1'b0);

    // Back-to-back with the consumer always ready; counter sits at DW-1 between ops.
    run_op(16'd7, 16'd9, 0, 1'b1);
    run_op(16'd100, 16'd200, 0, 1'b1);
    result_ready = 1'b0;

    // Abort in RUN cycle 5.
    multiplicand = 16'd50;
    multiplier   = 16'd3;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("run_busy", ready, 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_idle", ready, 1);
    check("clear_cnt_en", cnt_enable, 0);
    check("clear_product", product, last_prod);
    nvalid = 0;
    repeat (20) begin
      @(negedge clk);
      if (result_valid) nvalid++;
    end
    check("clear_no_valid", nvalid, 0);

    // Clear together with start in IDLE: no capture, stays idle.
    clear        = 1'b1;
    start        = 1'b1;
    multiplicand = 16'd9;
    multiplier   = 16'd9;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    check("clear_start_idle", ready, 1);
    check("clear_start_no_load", cnt_sync_reset, 0);
    run_op(16'd12, 16'd12, 0, 1'b0);

    // Async reset mid-RUN.
    multiplicand = 16'd77;
    multiplier   = 16'd99;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_ready", ready, 1);
    check("arst_valid", result_valid, 0);
    check("arst_product", product, 0);
    check("arst_cnt_en", cnt_enable, 0);
    check("arst_cnt_sr", cnt_sync_reset, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op(16'd2, 16'd2, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      run_op(W'($urandom), W'($urandom), i, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
